// File: rtl/hex_keypad_pkg.sv
// Shared types and the physical key layout for the 4x4 hex keypad scanner.
// The layout function maps a (row, col) crossing to the legend printed on that key.
package hex_keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } frame_class_t;

    localparam int DEF_SCAN_DIV_BITS  = 16;
    localparam int DEF_DEBOUNCE_SCANS = 4;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_fsm.sv
// Frame-rate debounce state machine: turns per-frame classifications into
// accepted key events, a held flag and the code of the last accepted key.
module keypad_debounce_fsm
    import hex_keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_end,
    input  logic [1:0] i_class,
    input  logic [3:0] i_code,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    output logic       o_key_held,
    output logic       o_accept,
    output logic [3:0] o_accept_code
);

    localparam logic [3:0] LP_TARGET = 4'(DEBOUNCE_SCANS);

    kp_state_t    r_state;
    kp_state_t    w_state_next;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_next;
    logic [3:0]   w_cnt_inc;
    logic [3:0]   r_cand;
    logic [3:0]   w_cand_next;
    logic [3:0]   r_key_code;
    logic         r_key_valid;
    logic         w_accept;
    frame_class_t w_class;

    assign w_class   = frame_class_t'(i_class);
    assign w_cnt_inc = (r_cnt >= LP_TARGET) ? LP_TARGET : r_cnt + 4'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_cand      <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cand      <= w_cand_next;
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= r_cand;
            end
        end
    end

    // A mismatching frame during debounce is discarded, not used as a new candidate.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_accept     = 1'b0;
        if (i_frame_end) begin
            case (r_state)
                IDLE: begin
                    if (w_class == CLS_SINGLE) begin
                        w_state_next = DEBOUNCE;
                        w_cand_next  = i_code;
                        w_cnt_next   = 4'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_class == CLS_SINGLE && i_code == r_cand) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == LP_TARGET) begin
                            w_state_next = PRESSED;
                            w_accept     = 1'b1;
                        end
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (w_class == CLS_NONE) begin
                        w_state_next = RELEASE;
                        w_cnt_next   = 4'd1;
                    end
                end
                RELEASE: begin
                    if (w_class == CLS_NONE) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == LP_TARGET) begin
                            w_state_next = IDLE;
                            w_cnt_next   = 4'd0;
                        end
                    end else begin
                        w_state_next = PRESSED;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign o_key_valid   = r_key_valid;
    assign o_key_code    = r_key_code;
    assign o_key_held    = (r_state == PRESSED) || (r_state == RELEASE);
    assign o_accept      = w_accept;
    assign o_accept_code = r_cand;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: row walker, column synchronizer, per-frame press map,
// classification and the four-key entry shift register.
module hex_keypad_scanner
    import hex_keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = DEF_SCAN_DIV_BITS,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [3:0]  o_rows,
    input  logic [3:0]  i_cols,
    input  logic        i_entry_clr,
    output logic [3:0]  o_key_code,
    output logic        o_key_valid,
    output logic        o_key_held,
    output logic [15:0] o_entry
);

    logic [SCAN_DIV_BITS-1:0] r_div;
    logic [1:0]               r_row_idx;
    logic [3:0]               r_cols_meta;
    logic [3:0]               r_cols_sync;
    logic [15:0]              r_press_map;
    logic [15:0]              r_entry;
    logic                     w_dwell_end;
    logic                     w_frame_end;
    logic [15:0]              w_full_map;
    logic [4:0]               w_hit_count;
    logic [3:0]               w_hit_idx;
    frame_class_t             w_class;
    logic [3:0]               w_code;
    logic                     w_accept;
    logic [3:0]               w_accept_code;

    assign w_dwell_end = &r_div;
    assign w_frame_end = w_dwell_end && (r_row_idx == 2'd3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div     <= '0;
            r_row_idx <= 2'd0;
        end else begin
            r_div <= r_div + SCAN_DIV_BITS'(1);
            if (w_dwell_end) begin
                r_row_idx <= r_row_idx + 2'd1;
            end
        end
    end

    assign o_rows = ~(4'b0001 << r_row_idx);

    // Idle columns read high, so the synchronizer resets to "nothing pressed".
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cols_meta <= 4'hF;
            r_cols_sync <= 4'hF;
        end else begin
            r_cols_meta <= i_cols;
            r_cols_sync <= r_cols_meta;
        end
    end

    // Map view that already includes the sample being taken this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_slice
            assign w_full_map[gi*4 +: 4] =
                (w_dwell_end && (r_row_idx == 2'(gi))) ? ~r_cols_sync : r_press_map[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_press_map <= 16'h0000;
        end else if (w_frame_end) begin
            r_press_map <= 16'h0000;
        end else if (w_dwell_end) begin
            r_press_map <= w_full_map;
        end
    end

    always_comb begin
        w_hit_count = 5'd0;
        w_hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_full_map[i]) begin
                w_hit_count = w_hit_count + 5'd1;
                w_hit_idx   = 4'(i);
            end
        end
        if (w_hit_count == 5'd0) begin
            w_class = CLS_NONE;
        end else if (w_hit_count == 5'd1) begin
            w_class = CLS_SINGLE;
        end else begin
            w_class = CLS_MULTI;
        end
        w_code = key_map(w_hit_idx[3:2], w_hit_idx[1:0]);
    end

    keypad_debounce_fsm #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_fsm (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_end   (w_frame_end),
        .i_class       (w_class),
        .i_code        (w_code),
        .o_key_valid   (o_key_valid),
        .o_key_code    (o_key_code),
        .o_key_held    (o_key_held),
        .o_accept      (w_accept),
        .o_accept_code (w_accept_code)
    );

    // A clear coinciding with an acceptance wipes the history before the new key lands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_entry <= 16'h0000;
        end else if (w_accept) begin
            r_entry <= {(i_entry_clr ? 12'h000 : r_entry[11:0]), w_accept_code};
        end else if (i_entry_clr) begin
            r_entry <= 16'h0000;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: frame-aligned keypad stimulus, directed scenarios
// plus a randomized phase, checked against a frame-level behavioural model.
module tb_hex_keypad_scanner;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        entry_clr = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry;
    logic [15:0] tb_keys = 16'h0000;

    int total = 0;
    int bad   = 0;

    // Legend of the key at bit r*4+c.
    logic [3:0] keymap [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'h0, 4'hF, 4'hE, 4'hD};

    bit          m_held;
    int          m_streak;
    int          m_gaps;
    logic [3:0]  m_cand;
    logic [3:0]  m_code;
    logic [15:0] m_entry;
    bit          m_acc;

    int          obs_pulses;
    logic [3:0]  obs_rows [0:15];

    hex_keypad_scanner #(
        .SCAN_DIV_BITS (2),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_rows      (rows),
        .i_cols      (cols),
        .i_entry_clr (entry_clr),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held),
        .o_entry     (entry)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its column low only while its row is driven.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (tb_keys[r*4+c] && !rows[r]) begin
                    cols[c] = 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] key_bit(input logic [3:0] code);
        logic [15:0] b;
        b = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (keymap[i] == code) b = 16'(1) << i;
        end
        return b;
    endfunction

    task automatic model_reset();
        m_held = 0; m_streak = 0; m_gaps = 0;
        m_cand = 4'h0; m_code = 4'h0; m_entry = 16'h0000; m_acc = 0;
    endtask

    // One whole frame as the keypad user sees it: N identical single-key frames
    // from rest are an accepted press, N empty frames end a press.
    task automatic model_frame(input logic [15:0] keys, input bit clr);
        int n;
        logic [3:0] code;
        n = $countones(keys);
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) code = keymap[i];
        end
        m_acc = 0;
        if (!m_held) begin
            if (m_streak > 0) begin
                if (n == 1 && code == m_cand) m_streak++;
                else m_streak = 0;
            end else if (n == 1) begin
                m_cand = code;
                m_streak = 1;
            end
            if (m_streak == DEB) begin
                m_acc = 1; m_held = 1; m_gaps = 0; m_streak = 0; m_code = m_cand;
            end
        end else begin
            m_gaps = (n == 0) ? m_gaps + 1 : 0;
            if (m_gaps == DEB) begin
                m_held = 0; m_gaps = 0;
            end
        end
        if (clr) m_entry = 16'h0000;
        if (m_acc) m_entry = (m_entry << 4) | {12'h000, m_code};
    endtask

    // Starts at the negedge of the first cycle of a frame, ends at the same point of the next.
    task automatic run_frame(input logic [15:0] keys, input bit clr);
        tb_keys = keys;
        model_frame(keys, clr);
        obs_pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            entry_clr = (i == 15) ? clr : 1'b0;
            if (key_valid) obs_pulses++;
            obs_rows[i % 16] = rows;
        end
        $display("frame keys=%h clr=%0d pulses=%0d code=%h held=%0d entry=%h",
                 keys, clr, obs_pulses, key_code, key_held, entry);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        tb_keys = 16'h0000;
        model_reset();
    endtask

    task automatic test_reset();
        logic [3:0] exp_rows;
        for (int f = 0; f < DEB; f++) begin
            run_frame(key_bit(4'h5), 0);
            total++;
            if (obs_pulses !== int'(m_acc)) begin
                bad++; $display("FAIL reset_pre_pulse frame=%0d got=%0d want=%0d", f, obs_pulses, m_acc);
            end
        end
        total++;
        if (key_code !== 4'h5 || key_held !== 1'b1) begin
            bad++; $display("FAIL reset_pre_state got code=%h held=%b want code=5 held=1", key_code, key_held);
        end
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (rows !== 4'b1110) begin
            bad++; $display("FAIL reset_rows got=%b want=1110", rows);
        end
        total++;
        if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0 || entry !== 16'h0000) begin
            bad++; $display("FAIL reset_outputs got valid=%b held=%b code=%h entry=%h want all zero",
                            key_valid, key_held, key_code, entry);
        end
        release_reset();
        run_frame(16'h0000, 0);
        for (int i = 0; i < 16; i++) begin
            exp_rows = ~(4'b0001 << (i / 4));
            total++;
            if (obs_rows[i] !== exp_rows) begin
                bad++; $display("FAIL reset_row_walk cycle=%0d got=%b want=%b", i, obs_rows[i], exp_rows);
            end
        end
    endtask

    task automatic test_single();
        for (int f = 0; f < 4; f++) begin
            run_frame(key_bit(4'h6), 0);
            total++;
            if (obs_pulses !== ((f == 3) ? 1 : 0)) begin
                bad++; $display("FAIL single_pulse frame=%0d got=%0d want=%0d", f, obs_pulses, (f == 3) ? 1 : 0);
            end
        end
        total++;
        if (key_code !== 4'h6 || entry !== 16'h0006 || key_held !== 1'b1) begin
            bad++; $display("FAIL single_state got code=%h entry=%h held=%b want code=6 entry=0006 held=1",
                            key_code, entry, key_held);
        end
        for (int f = 0; f < 4; f++) begin
            run_frame(16'h0000, 0);
            total++;
            if (key_held !== ((f == 3) ? 1'b0 : 1'b1) || obs_pulses !== 0) begin
                bad++; $display("FAIL single_release frame=%0d got held=%b pulses=%0d want held=%b pulses=0",
                                f, key_held, obs_pulses, (f == 3) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_sequence();
        logic [3:0] seq [0:4] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
        int pulses;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            for (int f = 0; f < 10; f++) begin
                run_frame((f < 5) ? key_bit(seq[k]) : 16'h0000, 0);
                pulses += obs_pulses;
                total++;
                if (obs_pulses !== int'(m_acc)) begin
                    bad++; $display("FAIL seq_pulse key=%h frame=%0d got=%0d want=%0d", seq[k], f, obs_pulses, m_acc);
                end
            end
            if (k == 3) begin
                total++;
                if (pulses !== 4 || entry !== 16'h123A) begin
                    bad++; $display("FAIL seq_entry4 got pulses=%0d entry=%h want pulses=4 entry=123a", pulses, entry);
                end
            end
        end
        total++;
        if (entry !== 16'h23A5) begin
            bad++; $display("FAIL seq_entry5 got=%h want=23a5", entry);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int f = 0; f < 10; f++) begin
            run_frame((f % 2 == 0) ? key_bit(4'h9) : 16'h0000, 0);
            pulses += obs_pulses;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL bounce_no_pulse got=%0d want=0", pulses);
        end
        pulses = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame(key_bit(4'h9), 0);
            pulses += obs_pulses;
        end
        total++;
        if (pulses !== 1 || key_code !== 4'h9) begin
            bad++; $display("FAIL bounce_steady got pulses=%0d code=%h want pulses=1 code=9", pulses, key_code);
        end
        for (int f = 0; f < 5; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_multi();
        int pulses;
        logic [15:0] both;
        both = key_bit(4'h5) | key_bit(4'h9);
        pulses = 0;
        for (int f = 0; f < 6; f++) begin
            run_frame(both, 0);
            pulses += obs_pulses;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL multi_no_pulse got=%0d want=0", pulses);
        end
        for (int f = 0; f < 4; f++) begin
            run_frame(key_bit(4'h5), 0);
            total++;
            if (obs_pulses !== ((f == 3) ? 1 : 0)) begin
                bad++; $display("FAIL multi_single_pulse frame=%0d got=%0d want=%0d", f, obs_pulses, (f == 3) ? 1 : 0);
            end
        end
        total++;
        if (key_code !== 4'h5) begin
            bad++; $display("FAIL multi_code got=%h want=5", key_code);
        end
        for (int f = 0; f < 3; f++) begin
            run_frame(both, 0);
            total++;
            if (obs_pulses !== 0 || key_held !== 1'b1) begin
                bad++; $display("FAIL multi_while_pressed frame=%0d got pulses=%0d held=%b want pulses=0 held=1",
                                f, obs_pulses, key_held);
            end
        end
        for (int f = 0; f < 5; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_clear();
        for (int k = 1; k <= 4; k++) begin
            for (int f = 0; f < 10; f++) run_frame((f < 5) ? key_bit(4'(k)) : 16'h0000, 0);
        end
        total++;
        if (entry !== 16'h1234) begin
            bad++; $display("FAIL clear_setup got=%h want=1234", entry);
        end
        for (int f = 0; f < 4; f++) run_frame(key_bit(4'hD), (f == 3));
        total++;
        if (obs_pulses !== 1 || entry !== 16'h000D) begin
            bad++; $display("FAIL clear_with_accept got pulses=%0d entry=%h want pulses=1 entry=000d", obs_pulses, entry);
        end
        for (int f = 0; f < 5; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_reset_corner();
        int pulses;
        run_frame(key_bit(4'h7), 0);
        run_frame(key_bit(4'h7), 0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
        rst = 1'b1;
        #1;
        total++;
        if (pulses !== 0 || key_valid !== 1'b0 || key_code !== 4'h0 || key_held !== 1'b0 || entry !== 16'h0000) begin
            bad++; $display("FAIL corner_reset got pulses=%0d valid=%b code=%h held=%b entry=%h want all zero",
                            pulses, key_valid, key_code, key_held, entry);
        end
        release_reset();
        for (int f = 0; f < 2; f++) begin
            run_frame(key_bit(4'h7), 0);
            total++;
            if (obs_pulses !== 0 || key_code !== 4'h0) begin
                bad++; $display("FAIL corner_after frame=%0d got pulses=%0d code=%h want pulses=0 code=0",
                                f, obs_pulses, key_code);
            end
        end
        for (int f = 0; f < 5; f++) run_frame(16'h0000, 0);
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int sel;
        int len;
        bit clr;
        for (int s = 0; s < 25; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) keys = 16'h0000;
            else if (sel < 8) keys = 16'(1) << $urandom_range(0, 15);
            else keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            len = $urandom_range(1, 6);
            for (int f = 0; f < len; f++) begin
                clr = ($urandom_range(0, 7) == 0);
                run_frame(keys, clr);
                total++;
                if (obs_pulses !== int'(m_acc) || key_code !== m_code || entry !== m_entry || key_held !== m_held) begin
                    bad++; $display("FAIL random seg=%0d frame=%0d got pulses=%0d code=%h entry=%h held=%b want pulses=%0d code=%h entry=%h held=%b",
                                    s, f, obs_pulses, key_code, entry, key_held, m_acc, m_code, m_entry, m_held);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #10;
        release_reset();
        test_reset();
        test_single();
        test_sequence();
        test_bounce();
        test_multi();
        test_clear();
        test_reset_corner();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
Scanned reader for a 4x4 hexadecimal matrix keypad: the input-side counterpart of the multiplexed 7-segment display driver. Walks one active-low row at a time, samples the active-low columns, and debounces on whole-frame granularity. Emits a one-cycle key event and keeps a 16-bit shift register of the last four keys. `entry` is sized to feed the 2-byte hex display directly.

Parameters:
SCAN_DIV_BITS, 16, row dwell is 2^SCAN_DIV_BITS clocks; frame = 4 dwells.
DEBOUNCE_SCANS, 4, consecutive identical frames needed to accept a press or a release (range 2..15).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rows  out  4  row drive, active-low, exactly one bit low at any time
cols  in  4  column sense, active-low, externally pulled up, asynchronous to clk
entry_clr  in  1  synchronous clear of entry
key_code  out  4  code of the last accepted key
key_valid  out  1  one-cycle pulse on key acceptance
key_held  out  1  high while an accepted key is considered pressed
entry  out  16  last four keys, newest in [3:0]

Behaviour:
- Reset (async, immediate):
  - rows=4'b1110; key_code=0; key_valid=0; key_held=0; entry=0.
  - Divider, row index and debounce count cleared; FSM=IDLE.
  - Reset mid-operation discards any in-progress debounce with no pulse.
- Scan:
  - Free-running divider; row_idx increments (3 wraps to 0) on the cycle the divider wraps to 0.
  - rows = ~(1 << row_idx).
  - cols pass through a 2-flop synchronizer.
  - Synchronized cols are sampled on the last cycle of each dwell (divider all-ones) into the 4-bit slice of a 16-bit press map for row_idx; bit = ~col.
- Key map (row r, col c -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Frame end: the sample of row 3. Classification: NONE (map==0), SINGLE(code) (exactly one bit set), MULTI (more than one bit). Press map is cleared for the next frame.
- FSM is evaluated only at frame end:
  - IDLE: SINGLE -> DEBOUNCE, cand=code, cnt=1; otherwise stay.
  - DEBOUNCE: SINGLE with code==cand -> cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED and, in the same cycle:
    - key_valid=1;
    - key_code=cand;
    - entry={entry[11:0],cand}.
    Any other class -> IDLE with no pulse.
  - PRESSED: key_held=1. NONE -> RELEASE, cnt=1. SINGLE (any code) or MULTI -> stay; no new event without a release.
  - RELEASE: key_held stays 1. NONE -> cnt++; when cnt reaches DEBOUNCE_SCANS go to IDLE and key_held=0. SINGLE or MULTI -> PRESSED.
- key_valid is high for exactly one clk; key_code holds its value until the next acceptance.
- Latency: a press stable from frame k is accepted at the end of frame k+DEBOUNCE_SCANS-1. The first frame may be partial and is rejected if its row sample missed the key.
- entry_clr: clears entry to 0 on the next edge.
  - If coincident with acceptance, clear applies first, then shift: entry={12'h000,cand}.
- MULTI keys are never accepted; ghosting is not resolved.
- Debounce counter saturates at DEBOUNCE_SCANS.

Decomposition:
- Package hex_keypad_pkg: FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE); frame class enum; key-map constant/function (row,col)->code; default parameter values.
- Sub-module keypad_debounce_fsm: takes frame_end, class and code; produces key_valid, key_code and key_held.
- Top level keeps the divider, row drive, synchronizer, press map and entry register.

Test Plan:
All scenarios run with SCAN_DIV_BITS=2 (dwell 4, frame 16 clocks) and DEBOUNCE_SCANS=4. The keypad model drives cols low only while the pressed key's row is low.
1. Reset:
   - Assert rst mid-frame -> rows=1110 and all outputs 0 immediately.
   - After release, rows walks 1110,1101,1011,0111 every 4 clocks.
2. Single key:
   - Hold key r1c2 from a frame start -> exactly one key_valid at the end of the 4th frame; key_code=6; entry=0x0006; key_held=1.
   - Release -> key_held=0 after 4 empty frames.
3. Sequence:
   - Keys 1,2,3,A, each held 5 frames with 5-frame gaps -> four pulses; entry=0x123A.
   - Pressing 5 then gives entry=0x23A5.
4. Bounce:
   - Key 9 toggled present/absent on alternate frames for 10 frames -> no key_valid.
   - Key 9 then held steady -> one pulse, code 9.
5. Multi/ghost:
   - Hold 5 and 9 together 6 frames -> no pulse.
   - Release 9 keeping 5 -> pulse with code 5 after 4 frames.
   - Add 9 while PRESSED -> no pulse, key_held stays 1.
6. Clear and reset corner:
   - entry=0x1234; assert entry_clr on the key_valid cycle for key D -> entry=0x000D.
   - Async rst during the 3rd DEBOUNCE frame of key 7 -> no pulse, key_code=0.
